// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port synchronous SRAM between instruction fetch
// and data access. Data has priority; a starvation limiter forces a fetch grant
// after STARVE_LIMIT consecutive data grants. One-cycle read data is steered back
// to the requester that issued the read.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cancel,
  // Instruction fetch port (read only)
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  // Data port
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  // SRAM port
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  // Performance counters
  output logic [31:0] perf_inst_cnt,
  output logic [31:0] perf_data_cnt
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [1:0]  rsp_sel_q, rsp_sel_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] perf_inst_q, perf_inst_d;
  logic [31:0] perf_data_q, perf_data_d;

  logic force_inst;
  logic gnt_inst;
  logic gnt_data;

  // Grant decision: data first unless the fetch has been starved long enough.
  always_comb begin
    force_inst = (starve_cnt_q == Limit) & inst_req & ~cancel;
    gnt_inst   = resetn & inst_req & ~cancel & (~data_req | force_inst);
    gnt_data   = resetn & data_req & ~gnt_inst;
    inst_ready = gnt_inst;
    data_ready = gnt_data;
  end

  // SRAM request mux; all fields zero when nothing is granted.
  always_comb begin
    ram_en    = gnt_inst | gnt_data;
    ram_wen   = 4'b0;
    ram_addr  = 32'b0;
    ram_wdata = 32'b0;
    if (gnt_data) begin
      ram_wen   = data_wen;
      ram_addr  = data_addr;
      ram_wdata = data_wdata;
    end else if (gnt_inst) begin
      ram_addr  = inst_addr;
    end
  end

  // Response steering; gating by resetn discards a read in flight across reset.
  always_comb begin
    inst_rvalid   = resetn & rsp_sel_q[1] & ~cancel;
    data_rvalid   = resetn & rsp_sel_q[0];
    inst_rdata    = inst_rvalid ? ram_rdata : 32'b0;
    data_rdata    = data_rvalid ? ram_rdata : 32'b0;
    perf_inst_cnt = resetn ? perf_inst_q : 32'b0;
    perf_data_cnt = resetn ? perf_data_q : 32'b0;
  end

  // Next-state for response tag, starvation counter and perf counters.
  always_comb begin
    // Writes complete at grant, so only data reads are tagged.
    rsp_sel_d = {gnt_inst, gnt_data & (data_wen == 4'b0)};

    starve_cnt_d = starve_cnt_q;
    if (gnt_inst | ~inst_req | cancel) begin
      starve_cnt_d = 4'd0;
    end else if (gnt_data & inst_req & (starve_cnt_q < Limit)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    perf_inst_d = perf_inst_q + {31'b0, gnt_inst};
    perf_data_d = perf_data_q + {31'b0, gnt_data};
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_sel_q    <= 2'b0;
      starve_cnt_q <= 4'd0;
      perf_inst_q  <= 32'b0;
      perf_data_q  <= 32'b0;
    end else begin
      rsp_sel_q    <= rsp_sel_d;
      starve_cnt_q <= starve_cnt_d;
      perf_inst_q  <= perf_inst_d;
      perf_data_q  <= perf_data_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed, table-driven bench for sram_arbiter (STARVE_LIMIT = 4).
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        resetn, cancel;
  logic        inst_req, inst_ready, inst_rvalid;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_ready, data_rvalid;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [31:0] perf_inst_cnt, perf_data_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cancel       (cancel),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_ready   (inst_ready),
    .inst_rvalid  (inst_rvalid),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wen     (data_wen),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_ready   (data_ready),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .ram_en       (ram_en),
    .ram_wen      (ram_wen),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .perf_inst_cnt(perf_inst_cnt),
    .perf_data_cnt(perf_data_cnt)
  );

  typedef struct {
    logic        rst_n;
    logic        can;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] rdata;
    logic        e_ir;
    logic        e_dr;
    logic        e_en;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iv;
    logic        e_dv;
    logic [31:0] e_pi;
    logic [31:0] e_pd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic rst_n, logic can, logic ireq, logic [31:0] iaddr,
    logic dreq, logic [3:0] dwen, logic [31:0] daddr, logic [31:0] dwdata,
    logic [31:0] rdata,
    logic e_ir, logic e_dr, logic e_en, logic [3:0] e_wen,
    logic [31:0] e_addr, logic [31:0] e_wdata, logic e_iv, logic e_dv,
    logic [31:0] e_pi, logic [31:0] e_pd);
    vec_t v;
    v.rst_n = rst_n; v.can = can; v.ireq = ireq; v.iaddr = iaddr;
    v.dreq = dreq; v.dwen = dwen; v.daddr = daddr; v.dwdata = dwdata;
    v.rdata = rdata; v.e_ir = e_ir; v.e_dr = e_dr; v.e_en = e_en;
    v.e_wen = e_wen; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_iv = e_iv; v.e_dv = e_dv; v.e_pi = e_pi; v.e_pd = e_pd;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    resetn     = v.rst_n;
    cancel     = v.can;
    inst_req   = v.ireq;
    inst_addr  = v.iaddr;
    data_req   = v.dreq;
    data_wen   = v.dwen;
    data_addr  = v.daddr;
    data_wdata = v.dwdata;
    ram_rdata  = v.rdata;
  endtask

  localparam logic [31:0] BFC = 32'hBFC0_0000;
  localparam logic [31:0] DW  = 32'hDEAD_0000;

  initial begin
    // rst can ireq iaddr dreq dwen daddr dwdata rdata | ir dr en wen addr wdata iv dv pi pd
    // Row 0: in reset, everything requested -> all outputs zero.
    vecs.push_back(mk(0,0,1,BFC,      1,4'h0,32'h100,DW,32'h1111_1111, 0,0,0,4'h0,0,0,0,0,0,0));
    // Row 1: idle.
    vecs.push_back(mk(1,0,0,0,        0,4'h0,0,0,32'h2222_2222,       0,0,0,4'h0,0,0,0,0,0,0));
    // Row 2: single fetch.
    vecs.push_back(mk(1,0,1,BFC,      0,4'h0,0,0,32'h3333_3333,       1,0,1,4'h0,BFC,0,0,0,0,0));
    // Row 3: fetch data returns.
    vecs.push_back(mk(1,0,0,0,        0,4'h0,0,0,32'h4444_4444,       0,0,0,4'h0,0,0,1,0,1,0));
    // Row 4: store with partial byte enables.
    vecs.push_back(mk(1,0,0,0,        1,4'h3,32'h10,32'hA5A5_5A5A,32'h5555_5555,
                      0,1,1,4'h3,32'h10,32'hA5A5_5A5A,0,0,1,0));
    // Row 5: no response after a store.
    vecs.push_back(mk(1,0,0,0,        0,4'h0,0,0,32'h6666_6666,       0,0,0,4'h0,0,0,0,0,1,1));
    // Rows 6-11: both requesting continuously -> D,D,D,D,I,D.
    vecs.push_back(mk(1,0,1,BFC+4,    1,4'h0,32'h20,DW,32'h7000_0006, 0,1,1,4'h0,32'h20,DW,0,0,1,1));
    vecs.push_back(mk(1,0,1,BFC+4,    1,4'h0,32'h24,DW,32'h7000_0007, 0,1,1,4'h0,32'h24,DW,0,1,1,2));
    vecs.push_back(mk(1,0,1,BFC+4,    1,4'h0,32'h28,DW,32'h7000_0008, 0,1,1,4'h0,32'h28,DW,0,1,1,3));
    vecs.push_back(mk(1,0,1,BFC+4,    1,4'h0,32'h2C,DW,32'h7000_0009, 0,1,1,4'h0,32'h2C,DW,0,1,1,4));
    vecs.push_back(mk(1,0,1,BFC+4,    1,4'h0,32'h2C,DW,32'h7000_000A, 1,0,1,4'h0,BFC+4,0,0,1,1,5));
    vecs.push_back(mk(1,0,1,BFC+8,    1,4'h0,32'h2C,DW,32'h7000_000B, 0,1,1,4'h0,32'h2C,DW,1,0,2,5));
    // Row 12: fetch alone; previous data read returns.
    vecs.push_back(mk(1,0,1,BFC+8,    0,4'h0,0,0,32'h7000_000C,       1,0,1,4'h0,BFC+8,0,0,1,2,6));
    // Row 13: cancel kills due fetch response and pending fetch; data still granted.
    vecs.push_back(mk(1,1,1,BFC+12,   1,4'h0,32'h30,DW,32'h7000_000D, 0,1,1,4'h0,32'h30,DW,0,0,3,6));
    // Row 14: data response unaffected by earlier cancel.
    vecs.push_back(mk(1,0,0,0,        0,4'h0,0,0,32'h7000_000E,       0,0,0,4'h0,0,0,0,1,3,7));
    // Row 15: data read, then reset in the next cycle.
    vecs.push_back(mk(1,0,0,0,        1,4'h0,32'h40,0,32'h7000_000F,  0,1,1,4'h0,32'h40,0,0,0,3,7));
    vecs.push_back(mk(0,0,1,BFC,      1,4'h0,32'h44,DW,32'h7000_0010, 0,0,0,4'h0,0,0,0,0,0,0));
    // Row 17: first cycle out of reset: no stale response, counters cleared.
    vecs.push_back(mk(1,0,0,0,        0,4'h0,0,0,32'h7000_0011,       0,0,0,4'h0,0,0,0,0,0,0));

    // Initial reset for two cycles.
    drive(mk(0,0,0,0,0,4'h0,0,0,0, 0,0,0,4'h0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk("inst_ready",    i, {31'b0, inst_ready},  {31'b0, vecs[i].e_ir});
      chk("data_ready",    i, {31'b0, data_ready},  {31'b0, vecs[i].e_dr});
      chk("ram_en",        i, {31'b0, ram_en},      {31'b0, vecs[i].e_en});
      chk("ram_wen",       i, {28'b0, ram_wen},     {28'b0, vecs[i].e_wen});
      chk("ram_addr",      i, ram_addr,             vecs[i].e_addr);
      chk("ram_wdata",     i, ram_wdata,            vecs[i].e_wdata);
      chk("inst_rvalid",   i, {31'b0, inst_rvalid}, {31'b0, vecs[i].e_iv});
      chk("inst_rdata",    i, inst_rdata,           vecs[i].e_iv ? vecs[i].rdata : 32'b0);
      chk("data_rvalid",   i, {31'b0, data_rvalid}, {31'b0, vecs[i].e_dv});
      chk("data_rdata",    i, data_rdata,           vecs[i].e_dv ? vecs[i].rdata : 32'b0);
      chk("perf_inst_cnt", i, perf_inst_cnt,        vecs[i].e_pi);
      chk("perf_data_cnt", i, perf_data_cnt,        vecs[i].e_pd);
    end

    // Perf counter wrap: preload data counter to all ones, then one data grant.
    @(negedge clk);
    drive(mk(1,0,0,0,0,4'h0,0,0,0, 0,0,0,4'h0,0,0,0,0,0,0));
    force dut.perf_data_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_data_q;
    #1;
    chk("perf_preload", 100, perf_data_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("perf_hold_idle", 101, perf_data_cnt, 32'hFFFF_FFFF);
    data_req  = 1'b1;
    data_addr = 32'h80;
    #1;
    chk("wrap_ready", 102, {31'b0, data_ready}, 32'd1);
    @(negedge clk);
    data_req = 1'b0;
    #1;
    chk("perf_wrap", 103, perf_data_cnt, 32'h0);
    chk("wrap_rvalid", 104, {31'b0, data_rvalid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

- Shares one single-port synchronous SRAM between the instruction-fetch requester (IF) and the data-access requester (MEM) of the five-stage core.
- Issues at most one access per cycle:
  - MEM has priority.
  - A starvation limiter guarantees fetch progress.
- Routes the one-cycle-latency read data back to the requester that issued it.
- Drops fetch responses when the writeback stage raises `cancel`.
- Sits between `mycpu_top` and the unified RAM.

## Interface

Parameters:
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while a fetch is pending; legal range 1..15.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `cancel` in 1: pipeline flush from WB; kills fetch traffic this cycle.
- `inst_req` in 1: fetch request, read only.
- `inst_addr` in 32: fetch byte address.
- `inst_ready` out 1: fetch request accepted this cycle.
- `inst_rvalid` out 1: fetch data valid.
- `inst_rdata` out 32: fetch data.
- `data_req` in 1: data request.
- `data_wen` in 4: byte write enables; 0 means read.
- `data_addr` in 32: data byte address.
- `data_wdata` in 32: store data.
- `data_ready` out 1: data request accepted this cycle.
- `data_rvalid` out 1: load data valid.
- `data_rdata` out 32: load data.
- `ram_en` out 1: SRAM enable.
- `ram_wen` out 4: SRAM byte write enables.
- `ram_addr` out 32: SRAM address.
- `ram_wdata` out 32: SRAM write data.
- `ram_rdata` in 32: SRAM read data, valid one cycle after a read enable.
- `perf_inst_cnt` out 32: count of issued fetches.
- `perf_data_cnt` out 32: count of issued data accesses.

## Operation

Grant, combinational from the current request inputs and registered state:
- `force_inst` = (`starve_cnt` == `STARVE_LIMIT`) & `inst_req` & ~`cancel`.
- `gnt_inst` = resetn & `inst_req` & ~`cancel` & (~`data_req` | `force_inst`).
- `gnt_data` = resetn & `data_req` & ~`gnt_inst`.
- `inst_ready` = `gnt_inst`; `data_ready` = `gnt_data`.

SRAM port:
- `ram_en` = `gnt_inst` | `gnt_data`.
- `ram_addr` and `ram_wdata` come from the granted requester.
- `ram_wen` = `data_wen` when data is granted, else 0.
- With no grant, `ram_addr`, `ram_wdata` and `ram_wen` are 0.

Response tag register `rsp_sel`, 2 bits:
- Holds {inst read issued, data read issued} from the previous cycle.
- Next value is {`gnt_inst`, `gnt_data` & (`data_wen` == 0)}.
- Writes complete at grant and produce no `data_rvalid`.

Response outputs:
- `inst_rvalid` = `rsp_sel[1]` & ~`cancel`.
- `data_rvalid` = `rsp_sel[0]`.
- Each `rdata` = `ram_rdata` when its `rvalid` is 1, else 0.

Starvation counter `starve_cnt`, 4 bits, next value:
- If `gnt_inst` or ~`inst_req` or `cancel`: 0.
- Else if `gnt_data` & `inst_req` & (`starve_cnt` < `STARVE_LIMIT`): +1.
- Otherwise: hold.

Performance counters:
- Each increments by 1 on its grant.
- Each wraps from 0xFFFFFFFF to 0.

## Timing

- Reset values:
  - All registered state is 0: `rsp_sel`, `starve_cnt`, both perf counters.
  - While `resetn`=0, every output is 0. Grants are gated by resetn, so no SRAM access occurs.
- Request acceptance has zero latency: `ready` is in the same cycle as `req`.
- Read data arrives 1 cycle after acceptance, as a single-cycle `rvalid` pulse.
  - Back-to-back reads produce `rvalid` on consecutive cycles.
- Simultaneous `inst_req` and `data_req`: data wins unless `force_inst`.
  - In the forced cycle data sees `data_ready`=0 and must hold its request.
- `cancel`:
  - Blocks a fetch grant in the same cycle; data may still be granted.
  - Suppresses an `inst_rvalid` due in that cycle.
  - Clears `starve_cnt`.
  - Has no effect on data responses.
- Reset mid-operation: an in-flight read response is discarded. The cycle after `resetn` deasserts shows `rvalid`=0.
- Requesters must hold `addr`, `wen` and `wdata` stable until `ready`.

## Test plan

- Idle then a single fetch at 0xBFC00000 -> `ram_en`=1 with `inst_ready`=1 in cycle T; `inst_rvalid`=1 with `inst_rdata`=`ram_rdata` in T+1; `perf_inst_cnt`=1.
- `inst_req` and `data_req` (read) both held continuously, `STARVE_LIMIT`=4 -> grant pattern D,D,D,D,I repeating; every read returns to the correct port one cycle later.
- Store with `data_wen`=4'b0011, `addr`=0x10, `wdata`=0xA5A55A5A -> `ram_wen`=4'b0011, `data_ready`=1, no `data_rvalid` in the next cycle.
- Fetch granted in T, `cancel`=1 in T+1 -> `inst_rvalid`=0 in T+1; a pending fetch in T+1 gets no grant; a data read in T+1 is granted.
- `resetn` low in the cycle after a data read grant -> `data_rvalid`=0; all outputs 0; perf counters 0 at the next edge.
- `perf_data_cnt` preloaded to 0xFFFFFFFF via forced state, one data grant -> counter reads 0.
